pitch_ol_lagmax: RTL

Parametrised open-loop pitch lag search engine for the G.729 encoder pitch path. On `start` it reads the weighted speech buffer from shared scratch memory and computes R(k) = Σ s[n]·s[n−k] for every lag k in a run-time range [pit_min, pit_max]. It returns the lag with maximum correlation and that correlation value. Sample width, accumulator width, history depth and memory placement are generics; it replaces the fixed-width single-range open-loop search.

---
 rtl/pitch_ol_lagmax.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/pitch_ol_lagmax.sv
// Open-loop pitch lag search: R(k) = sum s[n]*s[n-k] for k in [pit_min, pit_max], returns the best lag.
// Latency: 2 + (pit_max_c - pit_min + 1)*(2*N + 2) cycles from start to done; an illegal range takes 2 cycles.
// Backpressure: none. start is honoured only in IDLE; memory returns data one cycle after the address.
// Optional feature: define PITCH_OL_SAT_EN for G.729 L_mac saturating accumulation (default build wraps).
module pitch_ol_lagmax #(
  parameter int DATA_W    = 16,
  parameter int ACC_W     = 32,
  parameter int LAG_W     = 8,
  parameter int ADDR_W    = 12,
  parameter int MAX_LAG   = 143,
  parameter int BASE_ADDR = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [LAG_W-1:0]         L_frame,
  input  logic [LAG_W-1:0]         pit_min,
  input  logic [LAG_W-1:0]         pit_max,
  output logic [ADDR_W-1:0]        memReadAddr,
  input  logic signed [DATA_W-1:0] memIn,
  output logic                     done,
  output logic                     busy,
  output logic [LAG_W-1:0]         p_max1,
  output logic signed [ACC_W-1:0]  cor_max,
  output logic                     range_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_RD_X, S_RD_Y, S_DRAIN, S_CMP, S_DONE
  } state_t;

  localparam int PW = 2 * DATA_W;
  // Address of s[0]; history s[-MAX_LAG..-1] sits just below it.
  localparam logic [ADDR_W-1:0]       S0_ADDR   = ADDR_W'(BASE_ADDR + MAX_LAG);
  localparam logic [LAG_W-1:0]        MAX_LAG_L = LAG_W'(MAX_LAG);
  localparam logic signed [ACC_W-1:0] ACC_MIN   = {1'b1, {(ACC_W-1){1'b0}}};
`ifdef PITCH_OL_SAT_EN
  localparam logic signed [ACC_W-1:0] ACC_MAX   = {1'b0, {(ACC_W-1){1'b1}}};
  // min*min is the only product whose doubling overflows PW bits.
  localparam logic signed [PW-1:0]    PROD_OVF  = {2'b01, {(PW-2){1'b0}}};
  localparam logic signed [PW-1:0]    PROD_MAX  = {1'b0, {(PW-1){1'b1}}};
`endif

  state_t state, next_state;

  // Request captured at start so mid-run input changes are invisible.
  logic [LAG_W-1:0]        n_frame, lag_lo, lag_hi;
  logic [LAG_W-1:0]        k, n, best_lag;
  logic signed [ACC_W-1:0] acc, best_cor;
  logic signed [DATA_W-1:0] xs;
  logic                    pend;

  logic [LAG_W-1:0]        hi_c;
  logic                    illegal, frame_empty, last_term, last_lag, win;
  logic [LAG_W:0]          n_inc;
  logic signed [PW-1:0]    prod, prod_sh;
  logic signed [ACC_W-1:0] term, mac_sum;
`ifdef PITCH_OL_SAT_EN
  logic signed [ACC_W:0]   sum_w;
`endif

  // Range decode and loop-termination conditions.
  always_comb begin
    hi_c        = (lag_hi > MAX_LAG_L) ? MAX_LAG_L : lag_hi;
    illegal     = (lag_lo == '0) || (lag_lo > hi_c);
    frame_empty = (n_frame == '0);
    n_inc       = {1'b0, n} + (LAG_W+1)'(1);
    last_term   = (n_inc == {1'b0, n_frame});
    last_lag    = (k == lag_lo);
    win         = (acc >= best_cor);
  end

  // One L_mac step: acc + 2*s[n]*s[n-k], wrapping or saturating.
  always_comb begin
    prod    = PW'(xs) * PW'(memIn);
    prod_sh = prod <<< 1;
`ifdef PITCH_OL_SAT_EN
    if (prod == PROD_OVF) prod_sh = PROD_MAX;
    term    = ACC_W'(prod_sh);
    sum_w   = {acc[ACC_W-1], acc} + {term[ACC_W-1], term};
    if (sum_w[ACC_W] != sum_w[ACC_W-1])
      mac_sum = sum_w[ACC_W] ? ACC_MIN : ACC_MAX;
    else
      mac_sum = sum_w[ACC_W-1:0];
`else
    term    = ACC_W'(prod_sh);
    mac_sum = acc + term;
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= next_state;
  end

  // Next-state logic: two cycles per term, then drain and compare per lag.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (start) next_state = S_INIT;
      S_INIT:  if (illegal)          next_state = S_DONE;
               else if (frame_empty) next_state = S_DRAIN;
               else                  next_state = S_RD_X;
      S_RD_X:  next_state = S_RD_Y;
      S_RD_Y:  next_state = last_term ? S_DRAIN : S_RD_X;
      S_DRAIN: next_state = S_CMP;
      S_CMP:   if (last_lag)         next_state = S_DONE;
               else if (frame_empty) next_state = S_DRAIN;
               else                  next_state = S_RD_X;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Status outputs decoded from state.
  always_comb begin
    done = (state == S_DONE);
    busy = (state != S_IDLE);
  end

  // Read address is registered so it is valid throughout RD_X / RD_Y and holds otherwise.
  always_ff @(posedge clk) begin
    if (!reset) begin
      memReadAddr <= '0;
    end else if (next_state == S_RD_X) begin
      memReadAddr <= (state == S_RD_Y) ? S0_ADDR + ADDR_W'(n_inc) : S0_ADDR;
    end else if (next_state == S_RD_Y) begin
      memReadAddr <= S0_ADDR + ADDR_W'(n) - ADDR_W'(k);
    end
  end

  // Datapath: latch request, accumulate, track best lag, publish results in the done cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      n_frame   <= '0;
      lag_lo    <= '0;
      lag_hi    <= '0;
      k         <= '0;
      n         <= '0;
      acc       <= '0;
      best_cor  <= '0;
      best_lag  <= '0;
      xs        <= '0;
      pend      <= 1'b0;
      p_max1    <= '0;
      cor_max   <= '0;
      range_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            n_frame   <= L_frame;
            lag_lo    <= pit_min;
            lag_hi    <= pit_max;
            range_err <= 1'b0;
          end
        end
        S_INIT: begin
          k        <= hi_c;
          n        <= '0;
          acc      <= '0;
          pend     <= 1'b0;
          best_cor <= ACC_MIN;
          best_lag <= lag_lo;
          if (illegal) begin
            range_err <= 1'b1;
            p_max1    <= lag_lo;
            cor_max   <= ACC_MIN;
          end
        end
        // memIn now carries s[n-k] requested in the previous RD_Y.
        S_RD_X, S_DRAIN: begin
          if (pend) acc <= mac_sum;
          pend <= 1'b0;
        end
        // memIn now carries s[n] requested in the previous RD_X.
        S_RD_Y: begin
          xs   <= memIn;
          pend <= 1'b1;
          n    <= n_inc[LAG_W-1:0];
        end
        S_CMP: begin
          // >= on a descending scan lets the smaller lag win ties.
          if (win) begin
            best_cor <= acc;
            best_lag <= k;
          end
          if (last_lag) begin
            p_max1  <= win ? k : best_lag;
            cor_max <= win ? acc : best_cor;
          end
          acc <= '0;
          n   <= '0;
          k   <= k - LAG_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
